// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// Optional feature macro: MAIN_CTRL_IMM_ALU_EN (immediate ALU ops addi/andi/ori/slti).
package mips_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation codes, consumed by alu_control.Op_from_control
    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
    localparam logic [3:0] ALUOP_AND   = 4'b0011;
    localparam logic [3:0] ALUOP_OR    = 4'b0100;
    localparam logic [3:0] ALUOP_SLT   = 4'b0101;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
`ifdef MAIN_CTRL_IMM_ALU_EN
        ,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12
`endif
    } state_t;

    // True when DECODE has somewhere to dispatch this opcode.
    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef MAIN_CTRL_IMM_ALU_EN
        ok = ok || (op == OP_ADDI) || (op == OP_ANDI) ||
             (op == OP_ORI) || (op == OP_SLTI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/main_control_outdec.sv
// Combinational output decode for main_control_fsm: maps (state, opcode,
// mem_ready) onto every datapath control line. Only FETCH and the memory
// states look at mem_ready.
// Optional feature macro: MAIN_CTRL_IMM_ALU_EN.
module main_control_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  state_t             state,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal_op
);

    logic [3:0] alu_op_c;

    assign alu_op = ALUOP_W'(alu_op_c);

    // Per-state control decode; everything defaults low.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_source     = PCSRC_ALU;
        alu_op_c      = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !op_legal(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                ior_d      = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op_c  = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_c      = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MAIN_CTRL_IMM_ALU_EN
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ANDI: alu_op_c = ALUOP_AND;
                    OP_ORI:  alu_op_c = ALUOP_OR;
                    OP_SLTI: alu_op_c = ALUOP_SLT;
                    default: alu_op_c = ALUOP_ADD;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit: state register and next-state logic.
// All control outputs come from main_control_outdec.
// Optional feature macro: MAIN_CTRL_IMM_ALU_EN (builds I_EXEC/I_WB).
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | after reset, all outputs low
// FETCH    | read instruction, PC+4; waits on mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | compute lw/sw effective address
// MEM_RD   | data read; waits on mem_ready
// MEM_WB   | load result to register file
// MEM_WR   | data write; waits on mem_ready
// R_EXEC   | R-type ALU operation (funct-decoded)
// R_WB     | R-type result to rd
// BRANCH   | beq compare and conditional PC update
// JUMP     | j target into PC
// I_EXEC   | immediate ALU operation
// I_WB     | immediate result to rt
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal_op
);

    state_t state_q, state_d;

    // State register with synchronous reset into IDLE.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; memory waits hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MAIN_CTRL_IMM_ALU_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MAIN_CTRL_IMM_ALU_EN
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    main_control_outdec #(
        .ALUOP_W (ALUOP_W)
    ) u_outdec (
        .state         (state_q),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ior_d         (ior_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

endmodule
